// File: rtl/postprocess_pkg.sv
// Shared types and constants for the PostProcess linear-stage sequencer.
// Holds the FSM state encoding, datapath widths and class index values.
package postprocess_pkg;

  localparam int ITER_W  = 9;
  localparam int SCORE_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ISSUE  = ST_ISSUE,
    DRAIN  = ST_DRAIN,
    RESULT = ST_RESULT
  } state_t;

  localparam logic CLASS_0 = 1'b0;
  localparam logic CLASS_1 = 1'b1;

endpackage

// File: rtl/postprocess_linear_ctrl_if.sv
// Bus between the linear-stage sequencer and its host, buffers and datapath.
// master = sequencer side, slave = host/buffer/datapath side.
interface postprocess_linear_ctrl_if;
  import postprocess_pkg::*;

  // Handshake: start is a one-cycle request honoured only while busy=0;
  // busy rises the cycle after an accepted start and falls in the cycle
  // done pulses. class_out is valid from done and held until the next done.
  // rd_en/rd_addr are fire-and-forget strobes; lin_en/lin_iter follow them
  // RD_LAT cycles later with no back-pressure.
  logic                       start;
  logic                       hold;
  logic                       busy;
  logic                       rd_en;
  logic [ITER_W-1:0]          rd_addr;
  logic                       lin_en;
  logic [ITER_W-1:0]          lin_iter;
  logic signed [SCORE_W-1:0]  score0;
  logic signed [SCORE_W-1:0]  score1;
  logic                       done;
  logic                       class_out;

  modport master (
    input  start, hold, score0, score1,
    output busy, rd_en, rd_addr, lin_en, lin_iter, done, class_out
  );

  modport slave (
    output start, hold, score0, score1,
    input  busy, rd_en, rd_addr, lin_en, lin_iter, done, class_out
  );

endinterface

// File: rtl/pp_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// Aligns read strobes with the datapath enable after the memory read latency.
module pp_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/postprocess_linear_ctrl.sv
// Sequencer for the 2-class PostProcess linear stage: walks N_IN features,
// waits for the MAC pipeline to drain, then reports the argmax class.
module postprocess_linear_ctrl
  import postprocess_pkg::*;
#(
  parameter int N_IN    = 288,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_b,
  postprocess_linear_ctrl_if.master bus,
  output state_t                    state_dbg
);

  localparam int DRAIN_CYC = RD_LAT + MAC_LAT;
  localparam int CNT_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [ITER_W-1:0] LAST_IDX = ITER_W'(N_IN - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DRAIN_CYC - 1);

  state_t            state, state_nxt;
  logic [ITER_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              done_q, done_nxt;
  logic              class_q, class_nxt;
  logic              issue;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
      class_q <= CLASS_0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      done_q  <= done_nxt;
      class_q <= class_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    class_nxt = class_q;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ISSUE;
          idx_nxt   = '0;
        end
      end
      ISSUE: begin
        // idx parks on the last index so rd_addr holds it through DRAIN
        if (!bus.hold) begin
          issue = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt == LAST_CNT) state_nxt = RESULT;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      RESULT: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        class_nxt = ($signed(bus.score0) >= $signed(bus.score1)) ? CLASS_0 : CLASS_1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  pp_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (ITER_W + 1)
  ) u_align (
    .clk   (clk),
    .rst_b (rst_b),
    .d     ({issue, idx}),
    .q     ({bus.lin_en, bus.lin_iter})
  );

  assign bus.rd_en     = issue;
  assign bus.rd_addr   = idx;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.class_out = class_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_postprocess_linear_ctrl.sv
// Bench for postprocess_linear_ctrl: randomized runs checked by a
// spec-level model in a negedge monitor, plus a directed N_IN=1 build.
module tb_postprocess_linear_ctrl;
  import postprocess_pkg::*;

  localparam int N_IN    = 288;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 2;

  logic        clk;
  logic        rst_b;
  int unsigned cyc;
  int          tests_run;
  int          tests_failed;
  state_t      state0, state1;

  postprocess_linear_ctrl_if bus ();
  postprocess_linear_ctrl_if bus1 ();

  postprocess_linear_ctrl #(.N_IN(N_IN), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)) u_dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .state_dbg (state0)
  );

  postprocess_linear_ctrl #(.N_IN(1), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)) u_dut1 (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus1),
    .state_dbg (state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // reference model state and scoreboard
  bit          m_run, m_done_set;
  int unsigned m_start, m_done_cyc, m_issued;
  logic        m_class, m_exp_cls;
  logic [ITER_W-1:0] exp_q[$];
  int unsigned       exp_cyc_q[$];
  bit          exp_rd, exp_lin, exp_done;

  initial begin
    m_run = 0; m_done_set = 0; m_issued = 0; m_class = 1'b0; m_exp_cls = 1'b0;
    m_start = 0; m_done_cyc = 0;
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      m_run = 0; m_done_set = 0; m_issued = 0; m_class = 1'b0;
      exp_q.delete(); exp_cyc_q.delete();
      check("rst_busy", bus.busy, 0);
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_lin_en", bus.lin_en, 0);
      check("rst_done", bus.done, 0);
    end else begin
      exp_done = m_run && m_done_set && (cyc == m_done_cyc);
      if (exp_done) begin
        m_run   = 0;
        m_class = m_exp_cls;
      end
      check("done", bus.done, exp_done);
      check("class_out", bus.class_out, m_class);
      check("busy", bus.busy, m_run);

      exp_rd = 0;
      if (m_run && cyc > m_start && m_issued < N_IN && !bus.hold) begin
        exp_rd = 1;
        if (bus.rd_en) check("rd_addr", bus.rd_addr, m_issued);
        exp_q.push_back(ITER_W'(m_issued));
        exp_cyc_q.push_back(cyc + RD_LAT);
        m_issued++;
        if (m_issued == N_IN) begin
          m_done_set = 1;
          m_done_cyc = cyc + RD_LAT + MAC_LAT + 2;
        end
      end else if (!m_run && bus.start) begin
        m_run = 1; m_start = cyc; m_issued = 0; m_done_set = 0;
        m_exp_cls = (int'(bus.score0) >= int'(bus.score1)) ? 1'b0 : 1'b1;
      end
      check("rd_en", bus.rd_en, exp_rd);

      exp_lin = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      check("lin_en", bus.lin_en, exp_lin);
      if (exp_lin) begin
        void'(exp_cyc_q.pop_front());
        check("lin_iter", bus.lin_iter, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic run_inf(input logic [31:0] s0, input logic [31:0] s1,
                         input int mode, input bit extra);
    int unsigned s;
    int unsigned rel;
    bit seen;
    bus.score0 = s0;
    bus.score1 = s1;
    bus.start  = 1'b1;
    bus.hold   = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    s    = cyc;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      rel = cyc - s;
      bus.start = extra && (rel == 5 || rel == 50);
      case (mode)
        1:       bus.hold = (rel >= 10 && rel <= 14);
        2:       bus.hold = ($urandom_range(0, 3) == 0);
        default: bus.hold = 1'b0;
      endcase
      if (bus.done) begin
        seen = 1;
        if (mode == 0) check("done_latency", rel, N_IN + RD_LAT + MAC_LAT + 2);
        if (mode == 1) check("done_latency_hold", rel, N_IN + RD_LAT + MAC_LAT + 2 + 5);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    bus.hold  = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic reset_mid_run();
    bit hit;
    bus.score0 = 32'd1;
    bus.score1 = 32'd2;
    bus.start  = 1'b1;
    bus.hold   = 1'b0;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.rd_en && bus.rd_addr == 9'd100) hit = 1;
    end
    check("reach_idx100", hit, 1);
    rst_b = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_rd_en", bus.rd_en, 0);
    check("arst_rd_addr", bus.rd_addr, 0);
    check("arst_lin_en", bus.lin_en, 0);
    check("arst_lin_iter", bus.lin_iter, 0);
    check("arst_done", bus.done, 0);
    check("arst_class", bus.class_out, 0);
    check("arst_state", state0, IDLE);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("post_rst_state", state0, IDLE);
  endtask

  task automatic run_n1();
    int unsigned s;
    int unsigned r;
    bus1.score0 = 32'sd10;
    bus1.score1 = 32'sd20;
    bus1.start  = 1'b1;
    s = cyc;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus1.start = 1'b0;
      r = cyc - s;
      check("n1_rd_en", bus1.rd_en, r == 1);
      if (r == 1) check("n1_rd_addr", bus1.rd_addr, 0);
      check("n1_lin_en", bus1.lin_en, r == 2);
      if (r == 2) check("n1_lin_iter", bus1.lin_iter, 0);
      check("n1_busy", bus1.busy, r >= 1 && r <= 5);
      check("n1_done", bus1.done, r == 1 + RD_LAT + MAC_LAT + 2);
      if (r == 1 + RD_LAT + MAC_LAT + 2) check("n1_class", bus1.class_out, 1);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_b = 1'b0;
    bus.start = 1'b0;  bus.hold = 1'b0;  bus.score0 = '0;  bus.score1 = '0;
    bus1.start = 1'b0; bus1.hold = 1'b0; bus1.score0 = '0; bus1.score1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_class", bus.class_out, 0);
    check("reset_state", state0, IDLE);
    rst_b = 1'b1;
    @(posedge clk); #1;

    run_inf(-32'sd5, 32'sd3, 0, 1'b0);
    run_inf(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 1'b0);
    run_inf(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    run_inf(32'sd0, 32'sd0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      run_inf($urandom, $urandom, 2, ($urandom_range(0, 1) == 1));
    end
    reset_mid_run();
    run_inf(32'h0000_0007, 32'h8000_0000, 2, 1'b0);
    run_n1();

    repeat (10) @(posedge clk);
    #1;
    check("lin_queue_empty", exp_q.size(), 0);
    check("model_idle", m_run, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
